dac_spi_serializer: RTL and testbench
=====================================

Name: dac_spi_serializer

Overview:
- Downstream stage of the DAC channel pipeline. It takes the finished 16-bit offset-binary DAC output word for one channel and shifts it out to an AD5662-class serial DAC.
- The frame is 24 bits: 6 zero bits, 2 power-down bits, then 16 data bits, MSB first. Output lines are DAC_SYNC, DAC_SCLK and DAC_DIN.
- One instance per DAC channel. Each instance is triggered once per sample by the main sequencer.

Parameters:
- HALF_PERIOD, 1, dataclk cycles per SCLK half-period; legal range 1..255.
- GAP_CYCLES, 2, dataclk cycles SYNC is held high after a frame before the next start is accepted; legal range 1..255.
- PD_MODE, 2'b00, power-down bits placed in frame bits 17:16.

Ports:
- dataclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- SPI_start  in  1  one-cycle request to transmit DAC_word.
- DAC_en  in  1  channel enable, sampled with SPI_start.
- DAC_word  in  16  offset-binary sample, sampled with SPI_start.
- DAC_SYNC  out  1  frame sync, active low.
- DAC_SCLK  out  1  serial clock; idles high.
- DAC_DIN  out  1  serial data.
- busy  out  1  high while a frame or gap is in progress.
- done  out  1  one-cycle pulse at frame end, or at a disabled start.

Behaviour:
- Reset (reset=0 at a rising edge; next cycle values):
  - DAC_SYNC=1, DAC_SCLK=1, DAC_DIN=0, busy=0, done=0, state=IDLE.
  - Any in-progress frame is abandoned; no partial completion.
- States: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE:
  - SPI_start=1 with DAC_en=1 at cycle T0: latch frame = {6'b0, PD_MODE, DAC_word} into a 24-bit shift register.
  - At T1: DAC_SYNC=0, DAC_SCLK=1, DAC_DIN=frame[23], busy=1; enter SHIFT.
  - SPI_start=1 with DAC_en=0: no frame; done=1 at T1 for one cycle; busy stays 0; outputs stay idle.
- SHIFT:
  - Bit k (k=0..23, k=0 is frame[23]) is driven on DAC_DIN from T1+2*HALF_PERIOD*k.
  - DAC_SCLK=1 for the first HALF_PERIOD cycles of each bit and 0 for the second.
  - DIN changes only while SCLK is high (on SCLK rise), so the DAC samples a stable bit on the SCLK falling edge.
  - Half-period counter is 8 bits; bit counter is 5 bits (0..23). No wrap beyond 23.
- End of frame:
  - At TE = T1+48*HALF_PERIOD: DAC_SYNC=1, DAC_SCLK=1, DAC_DIN=0, done=1 for one cycle; enter GAP.
- GAP:
  - Hold the idle levels for GAP_CYCLES cycles. busy=1 through TE+GAP_CYCLES-1.
  - busy=0 at TE+GAP_CYCLES, state IDLE. SPI_start is accepted in that same cycle.
- SPI_start while busy=1 is ignored. DAC_word and DAC_en changes during a frame do not affect it.
- Reset and SPI_start in the same cycle: reset wins.
- Latency from start to first SCLK fall: 1+HALF_PERIOD cycles.
- Total busy time: 48*HALF_PERIOD+GAP_CYCLES cycles.

Optional Feature:
- Macro: DAC_SPI_PENDING_EN.
- Defined:
  - Adds a one-entry pending register (word and valid flag).
  - SPI_start with DAC_en=1 while busy=1 stores DAC_word; a later such start overwrites it (newest wins).
  - When GAP ends with a valid entry, the stored word is loaded and SYNC falls at TE+GAP_CYCLES+1 without an external start. The valid flag then clears.
  - A disabled start while busy clears any pending entry. Reset clears the entry.
- Undefined: starts during busy are dropped, as described above.

Test Plan:
- HALF_PERIOD=1, GAP_CYCLES=2, DAC_word=16'hA5C3, DAC_en=1, single start at T0 -> DIN sampled on SCLK falls = 24'h00A5C3 MSB-first; SYNC low T1..T48; done=1 at T49 (TE); busy 0 at T51.
- HALF_PERIOD=3, DAC_word=16'h8000 -> SCLK high 3 / low 3 cycles; SYNC low for 144 cycles; bit 8 (first data bit, value 1) at T1+48; all other bits 0.
- Start with DAC_en=0, DAC_word=16'hFFFF -> SYNC/SCLK stay 1, DIN=0, busy=0, done=1 at T1 only.
- Start 16'h1234, second start 16'hFFFF at T10 (undefined macro) -> only 24'h001234 shifted; no second frame; done pulses once.
- Reset asserted at T20 mid-frame -> at T21 SYNC=1, SCLK=1, DIN=0, busy=0, done=0; a new start at T22 produces a full, correct frame.
- DAC_SPI_PENDING_EN defined, starts 16'h1111 at T0, 16'h2222 at T5, 16'h3333 at T9 -> frames 001111 then 003333 back-to-back; second SYNC fall at TE+GAP_CYCLES+1; 2222 never appears.

Source files
------------

// File: rtl/dac_spi_serializer.sv
// Per-channel serializer for an AD5662-class DAC: 24-bit frame {6'b0, PD, word}, MSB first.
// Optional DAC_SPI_PENDING_EN adds a one-entry start queue that is used while a frame or gap is active.
module dac_spi_serializer #(
  parameter int         HALF_PERIOD = 1,
  parameter int         GAP_CYCLES  = 2,
  parameter logic [1:0] PD_MODE     = 2'b00
) (
  input  logic        dataclk,
  input  logic        reset,
  input  logic        SPI_start,
  input  logic        DAC_en,
  input  logic [15:0] DAC_word,
  output logic        DAC_SYNC,
  output logic        DAC_SCLK,
  output logic        DAC_DIN,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state, state_n;
  logic [23:0] sreg, sreg_n;
  logic [7:0]  hcnt, hcnt_n;
  logic [4:0]  bcnt, bcnt_n;
  logic [7:0]  gcnt, gcnt_n;
  logic        sync_n, sclk_n, din_n, done_n;
  logic        pend_vld;
  logic [15:0] pend_word;
  logic        start_en;
  logic [15:0] load_word;
  logic [23:0] frame;

  assign busy      = (state != IDLE);
  assign start_en  = SPI_start & DAC_en;
  // A live start is newer than anything queued, so it takes precedence.
  assign load_word = start_en ? DAC_word : pend_word;
  assign frame     = {6'b0, PD_MODE, load_word};

`ifdef DAC_SPI_PENDING_EN
  always_ff @(posedge dataclk) begin
    if (!reset) begin
      pend_vld  <= 1'b0;
      pend_word <= 16'h0;
    end else if (busy && SPI_start) begin
      pend_vld  <= DAC_en;
      if (DAC_en) pend_word <= DAC_word;
    end else if (state == IDLE) begin
      pend_vld  <= 1'b0;
    end
  end
`else
  assign pend_vld  = 1'b0;
  assign pend_word = 16'h0;
`endif

  always_ff @(posedge dataclk) begin
    if (!reset) begin
      state    <= IDLE;
      sreg     <= 24'h0;
      hcnt     <= 8'h0;
      bcnt     <= 5'h0;
      gcnt     <= 8'h0;
      DAC_SYNC <= 1'b1;
      DAC_SCLK <= 1'b1;
      DAC_DIN  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      sreg     <= sreg_n;
      hcnt     <= hcnt_n;
      bcnt     <= bcnt_n;
      gcnt     <= gcnt_n;
      DAC_SYNC <= sync_n;
      DAC_SCLK <= sclk_n;
      DAC_DIN  <= din_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    hcnt_n  = hcnt;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    sync_n  = DAC_SYNC;
    sclk_n  = DAC_SCLK;
    din_n   = DAC_DIN;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start_en || pend_vld) begin
          sreg_n  = frame;
          din_n   = frame[23];
          sync_n  = 1'b0;
          sclk_n  = 1'b1;
          hcnt_n  = 8'h0;
          bcnt_n  = 5'h0;
          state_n = SHIFT;
        end else if (SPI_start) begin
          done_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (hcnt == HP_LAST) begin
          hcnt_n = 8'h0;
          if (DAC_SCLK) begin
            sclk_n = 1'b0;
          end else if (bcnt == 5'd23) begin
            sync_n  = 1'b1;
            sclk_n  = 1'b1;
            din_n   = 1'b0;
            done_n  = 1'b1;
            gcnt_n  = 8'h0;
            state_n = GAP;
          end else begin
            // New bit is presented together with the SCLK rise.
            bcnt_n = bcnt + 5'd1;
            sreg_n = {sreg[22:0], 1'b0};
            din_n  = sreg[22];
            sclk_n = 1'b1;
          end
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end
      GAP: begin
        if (gcnt == GAP_LAST) state_n = IDLE;
        else                  gcnt_n  = gcnt + 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed bench for dac_spi_serializer: cycle-by-cycle check of {SYNC,SCLK,DIN,busy,done}.
module tb_dac_spi_serializer;

  logic        dataclk = 1'b0;
  logic        reset;
  logic        start0, start1, DAC_en;
  logic [15:0] DAC_word;
  logic        s0, c0, d0, b0, n0;
  logic        s1, c1, d1, b1, n1;
  int          checks = 0;
  int          errors = 0;

  always #5 dataclk = ~dataclk;

  dac_spi_serializer #(.HALF_PERIOD(1), .GAP_CYCLES(2), .PD_MODE(2'b00)) u0 (
    .dataclk(dataclk), .reset(reset), .SPI_start(start0), .DAC_en(DAC_en), .DAC_word(DAC_word),
    .DAC_SYNC(s0), .DAC_SCLK(c0), .DAC_DIN(d0), .busy(b0), .done(n0));

  dac_spi_serializer #(.HALF_PERIOD(3), .GAP_CYCLES(2), .PD_MODE(2'b00)) u1 (
    .dataclk(dataclk), .reset(reset), .SPI_start(start1), .DAC_en(DAC_en), .DAC_word(DAC_word),
    .DAC_SYNC(s1), .DAC_SCLK(c1), .DAC_DIN(d1), .busy(b1), .done(n1));

  // Expected {SYNC,SCLK,DIN,busy,done} at cycle n after a start accepted at cycle 0.
  function automatic logic [4:0] exp_vec(int n, int hp, int gap, logic [23:0] fr);
    int te;
    te = 48 * hp + 1;
    if (n >= 1 && n < te)
      return {1'b0, ((((n - 1) / hp) % 2) == 0), fr[23 - (n - 1) / (2 * hp)], 1'b1, 1'b0};
    else if (n == te)
      return 5'b11011;
    else if (n > te && n < te + gap)
      return 5'b11010;
    return 5'b11000;
  endfunction

  task automatic test_reset();
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0; DAC_en = 1'b0; DAC_word = 16'h0;
    repeat (3) @(negedge dataclk);
    checks++;
    if ({s0, c0, d0, b0, n0} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_u0: got %b expected %b", {s0, c0, d0, b0, n0}, 5'b11000);
    end
    checks++;
    if ({s1, c1, d1, b1, n1} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_u1: got %b expected %b", {s1, c1, d1, b1, n1}, 5'b11000);
    end
    reset = 1'b1;
    repeat (2) @(negedge dataclk);
  endtask

  task automatic test_basic_frame();
    logic [4:0] e;
    start0 = 1'b1; DAC_en = 1'b1; DAC_word = 16'hA5C3;
    for (int n = 1; n <= 53; n++) begin
      @(negedge dataclk);
      start0 = 1'b0;
      e = exp_vec(n, 1, 2, 24'h00A5C3);
      checks++;
      if ({s0, c0, d0, b0, n0} !== e) begin
        errors++;
        $display("FAIL basic_A5C3 cycle %0d: got %b expected %b", n, {s0, c0, d0, b0, n0}, e);
      end
    end
  endtask

  task automatic test_half_period3();
    logic [4:0] e;
    start1 = 1'b1; DAC_en = 1'b1; DAC_word = 16'h8000;
    for (int n = 1; n <= 150; n++) begin
      @(negedge dataclk);
      start1 = 1'b0;
      e = exp_vec(n, 3, 2, 24'h008000);
      checks++;
      if ({s1, c1, d1, b1, n1} !== e) begin
        errors++;
        $display("FAIL hp3_8000 cycle %0d: got %b expected %b", n, {s1, c1, d1, b1, n1}, e);
      end
    end
  endtask

  task automatic test_disabled();
    logic [4:0] e;
    start0 = 1'b1; DAC_en = 1'b0; DAC_word = 16'hFFFF;
    for (int n = 1; n <= 4; n++) begin
      @(negedge dataclk);
      start0 = 1'b0;
      e = (n == 1) ? 5'b11001 : 5'b11000;
      checks++;
      if ({s0, c0, d0, b0, n0} !== e) begin
        errors++;
        $display("FAIL disabled cycle %0d: got %b expected %b", n, {s0, c0, d0, b0, n0}, e);
      end
    end
    DAC_en = 1'b1;
  endtask

  task automatic test_busy_ignore();
    logic [4:0] e;
    start0 = 1'b1; DAC_en = 1'b1; DAC_word = 16'h1234;
    for (int n = 1; n <= 60; n++) begin
      @(negedge dataclk);
      e = exp_vec(n, 1, 2, 24'h001234);
      checks++;
      if ({s0, c0, d0, b0, n0} !== e) begin
        errors++;
        $display("FAIL busy_ignore cycle %0d: got %b expected %b", n, {s0, c0, d0, b0, n0}, e);
      end
      start0   = (n == 10);
      DAC_word = (n == 10) ? 16'hFFFF : 16'h1234;
    end
  endtask

  task automatic test_reset_midframe();
    logic [4:0] e;
    start0 = 1'b1; DAC_en = 1'b1; DAC_word = 16'hBEEF;
    for (int n = 1; n <= 20; n++) begin
      @(negedge dataclk);
      start0 = 1'b0;
      e = exp_vec(n, 1, 2, 24'h00BEEF);
      checks++;
      if ({s0, c0, d0, b0, n0} !== e) begin
        errors++;
        $display("FAIL pre_reset cycle %0d: got %b expected %b", n, {s0, c0, d0, b0, n0}, e);
      end
    end
    reset = 1'b0; start0 = 1'b1;
    @(negedge dataclk);
    checks++;
    if ({s0, c0, d0, b0, n0} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_midframe: got %b expected %b", {s0, c0, d0, b0, n0}, 5'b11000);
    end
    reset = 1'b1; start0 = 1'b0;
    @(negedge dataclk);
    checks++;
    if ({s0, c0, d0, b0, n0} !== 5'b11000) begin
      errors++;
      $display("FAIL after_reset: got %b expected %b", {s0, c0, d0, b0, n0}, 5'b11000);
    end
    start0 = 1'b1; DAC_word = 16'h0F0F;
    for (int n = 1; n <= 53; n++) begin
      @(negedge dataclk);
      start0 = 1'b0;
      e = exp_vec(n, 1, 2, 24'h000F0F);
      checks++;
      if ({s0, c0, d0, b0, n0} !== e) begin
        errors++;
        $display("FAIL post_reset_frame cycle %0d: got %b expected %b", n, {s0, c0, d0, b0, n0}, e);
      end
    end
  endtask

`ifdef DAC_SPI_PENDING_EN
  task automatic test_back_to_back();
    logic [4:0] e;
    start0 = 1'b1; DAC_en = 1'b1; DAC_word = 16'h1111;
    for (int n = 1; n <= 105; n++) begin
      @(negedge dataclk);
      e = (n <= 51) ? exp_vec(n, 1, 2, 24'h001111) : exp_vec(n - 51, 1, 2, 24'h003333);
      checks++;
      if ({s0, c0, d0, b0, n0} !== e) begin
        errors++;
        $display("FAIL pending_b2b cycle %0d: got %b expected %b", n, {s0, c0, d0, b0, n0}, e);
      end
      start0   = (n == 5) || (n == 9);
      DAC_word = (n == 5) ? 16'h2222 : (n == 9) ? 16'h3333 : 16'h0000;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_half_period3();
    test_disabled();
`ifndef DAC_SPI_PENDING_EN
    test_busy_ignore();
`else
    test_back_to_back();
`endif
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
